// File: rtl/oled_seq.sv
// oled_seq: command sequencer and bus master for the SPI OLED ctrl register bus.
// Host entries {op[1:0], byte[7:0]} are queued in a FIFO and expanded into the
// minimal series of ctrl writes (cs 0x04, data 0x08, dc 0x10, rst 0x14).
//   clk, resetn      clock, synchronous active-low reset
//   in_valid/ready   host entry handshake, in_data = {op, byte}
//                    op 00 cmd, 01 data, 10 reset pulse, 11 CS release
//   busy             FIFO non-empty or sequencer active
//   fifo_level       current FIFO occupancy
//   m_wr/addr/wdat   registered ctrl write request, held until m_done
//   m_done           one-cycle completion pulse from the peripheral
module oled_seq #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RST_CYCLES   = 1000,
  parameter int unsigned AUTO_RELEASE = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [9:0]                    in_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          m_wr,
  output logic [7:0]                    m_addr,
  output logic [31:0]                   m_wdat,
  input  logic                          m_done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_DC, S_CSLO, S_SEND,
    S_CS_HI, S_RST_LO, S_RST_W1, S_RST_HI, S_RST_W2
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [9:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [9:0]      cur_q, cur_d;
  logic            cs_active_q, cs_active_d;
  logic            dc_valid_q, dc_valid_d;
  logic            cur_dc_q, cur_dc_d;
  logic            rst_after_q, rst_after_d;
  logic [31:0]     wait_q, wait_d;
  logic [31:0]     idle_q, idle_d;
  logic            m_wr_q, m_wr_d;
  logic [7:0]      m_addr_q, m_addr_d;
  logic [31:0]     m_wdat_q, m_wdat_d;
  logic            push, pop;

  assign in_ready   = (level_q != LW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign busy       = (state_q != S_IDLE) || (level_q != '0);
  assign fifo_level = level_q;
  assign m_wr       = m_wr_q;
  assign m_addr     = m_addr_q;
  assign m_wdat     = m_wdat_q;

  // FIFO bookkeeping; pop only looks at registered occupancy, so there is no bypass.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cs_active_d = cs_active_q;
    dc_valid_d  = dc_valid_q;
    cur_dc_d    = cur_dc_q;
    rst_after_d = rst_after_q;
    wait_d      = wait_q;
    idle_d      = '0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          cur_d   = mem_q[rd_ptr_q];
          state_d = S_DECODE;
        end else if ((AUTO_RELEASE != 0) && cs_active_q && !push) begin
          // A push in this cycle leaves the count at zero; the entry is popped next cycle.
          if (idle_q == 32'(AUTO_RELEASE - 1)) begin
            state_d = S_CS_HI;
          end else begin
            idle_d = idle_q + 32'd1;
          end
        end
      end
      S_DECODE: begin
        case (cur_q[9:8])
          2'b00, 2'b01: begin
            if (!dc_valid_q || (cur_dc_q != cur_q[8])) state_d = S_DC;
            else if (!cs_active_q)                     state_d = S_CSLO;
            else                                       state_d = S_SEND;
          end
          2'b10: begin
            if (cs_active_q) begin
              rst_after_d = 1'b1;
              state_d     = S_CS_HI;
            end else begin
              state_d = S_RST_LO;
            end
          end
          default: state_d = cs_active_q ? S_CS_HI : S_IDLE;
        endcase
      end
      S_DC: begin
        if (m_done) begin
          cur_dc_d   = cur_q[8];
          dc_valid_d = 1'b1;
          state_d    = cs_active_q ? S_SEND : S_CSLO;
        end
      end
      S_CSLO: begin
        if (m_done) begin
          cs_active_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (m_done) state_d = S_IDLE;
      end
      S_CS_HI: begin
        if (m_done) begin
          cs_active_d = 1'b0;
          state_d     = rst_after_q ? S_RST_LO : S_IDLE;
        end
      end
      S_RST_LO: begin
        if (m_done) begin
          wait_d  = 32'(RST_CYCLES - 1);
          state_d = S_RST_W1;
        end
      end
      S_RST_W1: begin
        if (wait_q == '0) state_d = S_RST_HI;
        else              wait_d  = wait_q - 32'd1;
      end
      S_RST_HI: begin
        if (m_done) begin
          wait_d  = 32'(RST_CYCLES - 1);
          state_d = S_RST_W2;
        end
      end
      S_RST_W2: begin
        if (wait_q == '0) begin
          dc_valid_d  = 1'b0;
          rst_after_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request is decoded from the next state so it is registered and
  // follows the m_done edge directly, allowing back-to-back writes.
  always_comb begin
    m_wr_d   = 1'b0;
    m_addr_d = m_addr_q;
    m_wdat_d = m_wdat_q;
    case (state_d)
      S_DC:     begin m_wr_d = 1'b1; m_addr_d = 8'h10; m_wdat_d = {31'h0, cur_q[8]}; end
      S_CSLO:   begin m_wr_d = 1'b1; m_addr_d = 8'h04; m_wdat_d = 32'd0; end
      S_SEND:   begin m_wr_d = 1'b1; m_addr_d = 8'h08; m_wdat_d = {24'h0, cur_q[7:0]}; end
      S_CS_HI:  begin m_wr_d = 1'b1; m_addr_d = 8'h04; m_wdat_d = 32'd1; end
      S_RST_LO: begin m_wr_d = 1'b1; m_addr_d = 8'h14; m_wdat_d = 32'd0; end
      S_RST_HI: begin m_wr_d = 1'b1; m_addr_d = 8'h14; m_wdat_d = 32'd1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cur_q       <= '0;
      cs_active_q <= 1'b0;
      dc_valid_q  <= 1'b0;
      cur_dc_q    <= 1'b0;
      rst_after_q <= 1'b0;
      wait_q      <= '0;
      idle_q      <= '0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdat_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cur_q       <= cur_d;
      cs_active_q <= cs_active_d;
      dc_valid_q  <= dc_valid_d;
      cur_dc_q    <= cur_dc_d;
      rst_after_q <= rst_after_d;
      wait_q      <= wait_d;
      idle_q      <= idle_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wdat_q    <= m_wdat_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_oled_seq.sv
// tb_oled_seq: self-checking bench for oled_seq. Instance u_dut (no auto
// release) is checked write-by-write against a behavioural model of the ctrl
// write stream; u_dut_ar (AUTO_RELEASE=5) covers automatic CS release timing.
module tb_oled_seq;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_busy, a_m_wr, a_m_done = 1'b0;
  logic [9:0]  a_in_data = '0;
  logic [2:0]  a_level;
  logic [7:0]  a_m_addr;
  logic [31:0] a_m_wdat;

  logic        b_in_valid = 1'b0, b_in_ready, b_busy, b_m_wr, b_m_done = 1'b0;
  logic [9:0]  b_in_data = '0;
  logic [2:0]  b_level;
  logic [7:0]  b_m_addr;
  logic [31:0] b_m_wdat;

  oled_seq #(.FIFO_DEPTH(4), .RST_CYCLES(10), .AUTO_RELEASE(0)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .busy(a_busy), .fifo_level(a_level), .m_wr(a_m_wr),
    .m_addr(a_m_addr), .m_wdat(a_m_wdat), .m_done(a_m_done));

  oled_seq #(.FIFO_DEPTH(4), .RST_CYCLES(10), .AUTO_RELEASE(5)) u_dut_ar (
    .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .busy(b_busy), .fifo_level(b_level), .m_wr(b_m_wr),
    .m_addr(b_m_addr), .m_wdat(b_m_wdat), .m_done(b_m_done));

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ctrl writes implied by each entry, {addr[7:0], data[31:0]}.
  logic [39:0] exp_q[$];
  bit m_cs = 0, m_dcv = 0, m_dc = 0;

  task automatic model_entry(input logic [9:0] e);
    case (e[9:8])
      2'b00, 2'b01: begin
        if (!m_dcv || (m_dc != e[8])) begin
          exp_q.push_back({8'h10, 31'h0, e[8]});
          m_dcv = 1; m_dc = e[8];
        end
        if (!m_cs) begin
          exp_q.push_back({8'h04, 32'd0});
          m_cs = 1;
        end
        exp_q.push_back({8'h08, 24'h0, e[7:0]});
      end
      2'b10: begin
        if (m_cs) begin exp_q.push_back({8'h04, 32'd1}); m_cs = 0; end
        exp_q.push_back({8'h14, 32'd0});
        exp_q.push_back({8'h14, 32'd1});
        m_dcv = 0;
      end
      default: begin
        if (m_cs) begin exp_q.push_back({8'h04, 32'd1}); m_cs = 0; end
      end
    endcase
  endtask

  // Peripheral model for u_dut: m_done after 'lat' waiting cycles unless held.
  int unsigned lat = 1;
  bit hold = 0;
  int unsigned a_wr_count = 0;
  logic [39:0] a_log[$];
  int unsigned a_done_cyc[$];
  int unsigned a_start_cyc[$];

  initial begin
    logic [39:0] cap, cur, e;
    int unsigned wcnt, st;
    bit have;
    wcnt = 0; st = 0; have = 0;
    forever begin
      @(negedge clk);
      if (a_m_done) begin
        a_m_done = 1'b0; wcnt = 0; have = 0;
      end else if (!a_m_wr) begin
        wcnt = 0; have = 0;
      end else begin
        if (!have) begin cap = {a_m_addr, a_m_wdat}; st = cyc; have = 1; end
        if (!hold && wcnt >= lat) begin
          a_m_done = 1'b1;
          cur = {a_m_addr, a_m_wdat};
          a_log.push_back(cur); a_done_cyc.push_back(cyc); a_start_cyc.push_back(st);
          a_wr_count++;
          if (exp_q.size() == 0) begin
            check_eq("sb_extra_write", 64'(cur), '1);
          end else begin
            e = exp_q.pop_front();
            check_eq("sb_write_first_cycle", 64'(cap), 64'(e));
            check_eq("sb_write_at_done", 64'(cur), 64'(e));
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Peripheral model for u_dut_ar: immediate completion, logs writes.
  logic [39:0] b_log[$];
  int unsigned b_done_cyc[$];
  int unsigned b_start_cyc[$];

  initial forever begin
    @(negedge clk);
    if (b_m_done) begin
      b_m_done = 1'b0;
    end else if (b_m_wr) begin
      b_m_done = 1'b1;
      b_log.push_back({b_m_addr, b_m_wdat});
      b_done_cyc.push_back(cyc);
      b_start_cyc.push_back(cyc);
    end
  end

  task automatic push_a(input logic [9:0] d);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check_eq("push_ready_timeout", a_in_ready, 1);
    a_in_valid = 1'b1; a_in_data = d;
    model_entry(d);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, output int unsigned at);
    int unsigned n;
    n = 0;
    while (a_busy && n < 20000) begin @(negedge clk); n++; end
    if (a_busy) check_eq(tag, a_busy, 0);
    at = cyc;
  endtask

  task automatic push_b(input logic [9:0] d);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  initial begin
    int unsigned t, base, n, d2;
    bit seen;
    logic [1:0] op;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rst_m_wr", a_m_wr, 0);
    check_eq("rst_m_addr", a_m_addr, 0);
    check_eq("rst_m_wdat", a_m_wdat, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_level", a_level, 0);
    check_eq("rst_in_ready", a_in_ready, 1);

    // Burst: cmd AE, cmd D5, data 80 with 3-cycle completion latency.
    lat = 3;
    push_a(10'h0AE); push_a(10'h0D5); push_a(10'h180);
    wait_idle_a("t1_idle_timeout", t);
    check_eq("t1_write_count", a_log.size(), 6);
    check_eq("t1_busy_fall", t - a_done_cyc[a_done_cyc.size()-1], 1);
    n = 0;
    foreach (a_log[i]) if (a_log[i][39:32] == 8'h04) n++;
    check_eq("t1_cs_writes", n, 1);

    // Reset pulse while CS is active.
    lat = 1;
    base = a_log.size();
    push_a(10'h200);
    wait_idle_a("t2_idle_timeout", t);
    check_eq("t2_write_count", a_log.size() - base, 3);
    if (a_log.size() - base == 3) begin
      check_eq("t2_rst_gap", a_start_cyc[base+2] - a_done_cyc[base+1] - 1, 10);
      check_eq("t2_rst_settle", t - a_done_cyc[base+2], 11);
    end
    base = a_log.size();
    push_a(10'h03C);
    wait_idle_a("t2b_idle_timeout", t);
    check_eq("t2_post_rst_writes", a_log.size() - base, 3);

    // Fill the FIFO with completions held off.
    hold = 1; lat = 0;
    push_a(10'h111);
    repeat (3) @(negedge clk);
    check_eq("t3_first_popped", a_level, 0);
    push_a(10'h022); push_a(10'h133); push_a(10'h044);
    check_eq("t3_ready_at_3", a_in_ready, 1);
    push_a(10'h155);
    check_eq("t3_level_full", a_level, 4);
    check_eq("t3_ready_full", a_in_ready, 0);
    a_in_valid = 1'b1; a_in_data = 10'h1EE;
    repeat (3) begin
      @(negedge clk);
      check_eq("t3_refused_level", a_level, 4);
    end
    hold = 0;
    n = 0;
    while (!a_in_ready && n < 500) begin @(negedge clk); n++; end
    a_in_valid = 1'b0;
    check_eq("t3_level_after_pop", a_level, 3);
    wait_idle_a("t3_idle_timeout", t);
    check_eq("t3_drain", exp_q.size(), 0);

    // CS release: first with CS active, then with CS already released.
    push_a(10'h300);
    wait_idle_a("t5_idle_timeout", t);
    base = a_wr_count;
    push_a(10'h300);
    seen = 0;
    @(negedge clk);
    seen |= a_m_wr;
    check_eq("t5_consumed", a_level, 0);
    @(negedge clk);
    seen |= a_m_wr;
    check_eq("t5_not_busy", a_busy, 0);
    repeat (5) begin @(negedge clk); seen |= a_m_wr; end
    check_eq("t5_no_m_wr", seen, 0);
    check_eq("t5_write_count", a_wr_count - base, 0);

    // Randomized entry stream.
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 99);
      op = (n < 45) ? 2'b00 : (n < 90) ? 2'b01 : (n < 95) ? 2'b10 : 2'b11;
      lat = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_a({op, 8'($urandom)});
    end
    wait_idle_a("rand_idle_timeout", t);
    check_eq("rand_drain", exp_q.size(), 0);

    // Automatic CS release on u_dut_ar.
    push_b(10'h155);
    repeat (40) @(negedge clk);
    check_eq("ar_write_count1", b_log.size(), 4);
    if (b_log.size() >= 4) begin
      check_eq("ar_byte55", b_log[2], {8'h08, 32'h55});
      check_eq("ar_release1", b_log[3], {8'h04, 32'd1});
      check_eq("ar_release1_delay", b_start_cyc[3] - b_done_cyc[2], 6);
    end
    push_b(10'h166);
    n = 0;
    while (b_log.size() < 6 && n < 100) begin @(negedge clk); n++; end
    check_eq("ar_byte66_seen", b_log.size(), 6);
    if (b_log.size() >= 6) begin
      d2 = b_done_cyc[5];
      while (cyc < d2 + 3) @(negedge clk);
      b_in_valid = 1'b1; b_in_data = 10'h177;
      @(negedge clk);
      b_in_valid = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("ar_write_count2", b_log.size(), 8);
      if (b_log.size() >= 8) begin
        check_eq("ar_byte66", b_log[5], {8'h08, 32'h66});
        check_eq("ar_no_early_release", b_log[6], {8'h08, 32'h77});
        check_eq("ar_release2", b_log[7], {8'h04, 32'd1});
        check_eq("ar_release2_delay", b_start_cyc[7] - b_done_cyc[6], 6);
      end
    end

    // Reset in the middle of a SEND write.
    lat = 3; hold = 0;
    push_a(10'h1A5);
    n = 0;
    while (!(a_m_wr && a_m_addr == 8'h08) && n < 200) begin @(negedge clk); n++; end
    check_eq("t7_send_seen", a_m_wr && (a_m_addr == 8'h08), 1);
    hold = 1;
    resetn = 1'b0;
    @(negedge clk);
    check_eq("t7_m_wr", a_m_wr, 0);
    check_eq("t7_level", a_level, 0);
    check_eq("t7_busy", a_busy, 0);
    check_eq("t7_in_ready", a_in_ready, 1);
    check_eq("t7_m_addr", a_m_addr, 0);
    resetn = 1'b1;
    exp_q.delete();
    m_cs = 0; m_dcv = 0; m_dc = 0;
    hold = 0;
    base = a_log.size();
    push_a(10'h05A);
    wait_idle_a("t7_idle_timeout", t);
    check_eq("t7_restart_writes", a_log.size() - base, 3);
    check_eq("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_seq.md
Name: oled_seq

Overview:
- Command sequencer and bus master for the SPI OLED peripheral's ctrl register bus (prescale 0x00, cs 0x04, data 0x08, mode 0x0C, dc 0x10, rst 0x14).
- The CPU, or a future framebuffer streamer, pushes tagged entries into an internal FIFO: command byte, data byte, reset pulse, or CS release.
- The block turns each entry into the minimal series of ctrl writes, so CS/DC/RST handling is no longer done by software.

Parameters:
- FIFO_DEPTH, 16: entries in the input FIFO; must be a power of 2, minimum 2.
- RST_CYCLES, 1000: clk cycles that RST is held low, and also the settle time after RST is released; minimum 1.
- AUTO_RELEASE, 0: idle clk cycles with the FIFO empty and CS active before CS is released automatically; 0 disables this.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- in_valid  in  1  host entry valid
- in_ready  out  1  FIFO can accept an entry
- in_data  in  10  {op[1:0], byte[7:0]}; op 00 = cmd (DC=0), 01 = data (DC=1), 10 = reset pulse, 11 = CS release
- busy  out  1  FIFO non-empty or sequencer not IDLE
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- m_wr  out  1  ctrl write request
- m_addr  out  8  ctrl address
- m_wdat  out  32  ctrl write data
- m_done  in  1  one-cycle completion pulse from the peripheral

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. All state is updated on posedge clk.
- Reset values:
  - m_wr=0, m_addr=0, m_wdat=0, busy=0, fifo_level=0, in_ready=1.
  - FIFO empty, cs_active=0, dc_valid=0, state IDLE.
- Reset mid-transaction abandons everything with no CS/RST cleanup. The peripheral shares resetn, so its own reset returns CS high and RST high.
- FIFO:
  - Push when in_valid && in_ready. in_ready = !full.
  - A push is refused when full even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - No bypass: an entry pushed into an empty FIFO can be popped on the next cycle at the earliest.
  - Pointers wrap modulo FIFO_DEPTH.
- Master handshake:
  - m_wr, m_addr and m_wdat are registered and held stable until m_done is sampled high.
  - On the edge where m_done=1, the sequencer either drops m_wr or presents the next write, with m_wr=1, in the following cycle.
  - The peripheral ignores the m_done cycle, so back-to-back writes are legal.
  - m_wdat upper bits are always 0.
- States:
  - IDLE: if the FIFO is non-empty, pop the entry into cur (1 cycle) and go to DECODE.
    - If the FIFO is empty, cs_active=1 and AUTO_RELEASE>0: count idle cycles, reset the count on any push, and go to CS_HI when the count reaches AUTO_RELEASE.
  - DECODE:
    - op 00/01: go to DC if !dc_valid or cur_dc != op[0]; otherwise go to CSLO if !cs_active; otherwise go to SEND.
    - op 10: go to CS_HI if cs_active (with the pending flag rst_after=1); otherwise go to RST_LO.
    - op 11: go to CS_HI if cs_active; otherwise go to IDLE (no bus activity).
  - DC: write 0x10 = op[0]; on m_done set cur_dc and dc_valid, then go to CSLO or SEND.
  - CSLO: write 0x04 = 0; on m_done set cs_active=1 and go to SEND.
  - SEND: write 0x08 = byte; on m_done go to IDLE. CS stays low across consecutive bytes (burst).
  - CS_HI: write 0x04 = 1; on m_done clear cs_active, then go to RST_LO if rst_after, otherwise IDLE.
  - RST_LO: write 0x14 = 0; on m_done go to RST_W1.
  - RST_W1: wait exactly RST_CYCLES cycles, then go to RST_HI.
  - RST_HI: write 0x14 = 1; on m_done go to RST_W2.
  - RST_W2: wait RST_CYCLES cycles, clear dc_valid and rst_after, then go to IDLE.
- Wait counter is a 32-bit down-counter loaded on entry to RST_W1/RST_W2.
- busy=1 whenever state != IDLE or fifo_level != 0.
- No ctrl reads are issued. The prescale and mode registers are owned by software and must not be written while busy.

Test Plan:
- Push cmd 0xAE, cmd 0xD5, data 0x80 with m_done returned 3 cycles after each m_wr:
  - Required bus writes: 0x10=0, 0x04=0, 0x08=0xAE, 0x08=0xD5, 0x10=1, 0x08=0x80.
  - CS is written only once; busy falls 1 cycle after the last m_done.
- Push reset pulse with RST_CYCLES=10 while cs_active:
  - Required writes: 0x04=1, 0x14=0, a gap of exactly 10 cycles, 0x14=1, a 10-cycle wait.
  - The next cmd byte must re-emit 0x10=0 and 0x04=0.
- Fill FIFO_DEPTH=4 with m_done held low:
  - in_ready drops after 4 pushes and fifo_level=4.
  - A 5th push is refused, including in the cycle a pop occurs.
  - After release, all 4 entries are sent in order.
- AUTO_RELEASE=5, single data byte 0x55, FIFO then idle:
  - 0x04=1 is issued after 5 idle cycles.
  - A push arriving at idle cycle 3 restarts the count and no release occurs before that byte.
- CS release op with cs_active=0 -> no m_wr at all; the entry is consumed within 2 cycles.
- Assert resetn=0 mid-SEND with m_wr=1 -> next cycle m_wr=0, fifo_level=0, busy=0, in_ready=1.
